// File: rtl/ram_arbiter_pkg.sv
// Shared bus definitions: read-return owner tag and the data-RAM chip-select tag
// used by the instantiating top.
package bus_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_A    = 2'd1,
      OWNER_B    = 2'd2
   } owner_t;

   localparam logic [3:0] BUS_TAG_DATA = 4'h8;

   function automatic owner_t other_port(input owner_t p);
      return (p == OWNER_A) ? OWNER_B : OWNER_A;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's bus: request/accept handshake plus one-cycle-latency read return.
interface ram_arbiter_if;
   logic        req;
   logic [31:0] addr;
   logic        wren;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, wren, wdata, wmask,
                   input  ready, rvalid, rdata);
   modport slave  (input  req, addr, wren, wdata, wmask,
                   output ready, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational two-way round-robin pick; a port keeps the RAM for at most
// MAX_BURST consecutive grants while the other port is waiting.
module rr_pick
   import bus_pkg::*;
#(
   parameter int MAX_BURST = 4,
   localparam int RUN_W    = $clog2(MAX_BURST + 1)
) (
   input  logic             a_req_i,
   input  logic             b_req_i,
   input  owner_t           last_grant_i,
   input  logic [RUN_W-1:0] run_i,
   output owner_t           winner_o
);

   always_comb begin
      winner_o = OWNER_NONE;
      if (a_req_i && b_req_i) begin
         winner_o = (run_i < RUN_W'(MAX_BURST)) ? last_grant_i : other_port(last_grant_i);
      end else if (a_req_i) begin
         winner_o = OWNER_A;
      end else if (b_req_i) begin
         winner_o = OWNER_B;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-ported block RAM between two requesters with zero-cycle
// accept and routes the one-cycle-latency read data back to the issuing port.
module ram_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clock,
   input  logic                  reset_in,
   ram_arbiter_if.slave          a,
   ram_arbiter_if.slave          b,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_cs,
   output logic                  ram_wren,
   output logic [31:0]           ram_wdata,
   output logic [3:0]            ram_wmask,
   input  logic [31:0]           ram_rdata
);

   localparam int RUN_W = $clog2(MAX_BURST + 1);

   owner_t           last_grant_q, last_grant_d;
   owner_t           rd_owner_q, rd_owner_d;
   logic [RUN_W-1:0] run_q, run_d;
   owner_t           pick;
   owner_t           grant;
   logic             a_rvalid;
   logic             b_rvalid;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{a.addr[31:ADDR_WIDTH], b.addr[31:ADDR_WIDTH]};

   rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
      .a_req_i      (a.req),
      .b_req_i      (b.req),
      .last_grant_i (last_grant_q),
      .run_i        (run_q),
      .winner_o     (pick)
   );

   // Reset blocks every grant so the RAM sees no strobe while state is being cleared.
   assign grant   = reset_in ? OWNER_NONE : pick;
   assign a.ready = (grant == OWNER_A);
   assign b.ready = (grant == OWNER_B);

   always_comb begin
      ram_cs       = 1'b0;
      ram_wren     = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;
      ram_wmask    = '0;
      case (grant)
         OWNER_A: begin
            ram_cs    = 1'b1;
            ram_wren  = a.wren;
            ram_addr  = a.addr[ADDR_WIDTH-1:0];
            ram_wdata = a.wdata;
            ram_wmask = a.wmask;
         end
         OWNER_B: begin
            ram_cs    = 1'b1;
            ram_wren  = b.wren;
            ram_addr  = b.addr[ADDR_WIDTH-1:0];
            ram_wdata = b.wdata;
            ram_wmask = b.wmask;
         end
         default: ;
      endcase

      last_grant_d = last_grant_q;
      run_d        = '0;
      rd_owner_d   = OWNER_NONE;
      if (grant != OWNER_NONE) begin
         if (grant == last_grant_q) begin
            run_d = (run_q == RUN_W'(MAX_BURST)) ? run_q : run_q + RUN_W'(1);
         end else begin
            last_grant_d = grant;
            run_d        = RUN_W'(1);
         end
         if (!ram_wren) begin
            rd_owner_d = grant;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset_in) begin
         last_grant_q <= OWNER_A;
         run_q        <= '0;
         rd_owner_q   <= OWNER_NONE;
      end else begin
         last_grant_q <= last_grant_d;
         run_q        <= run_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // A read accepted just before reset must not surface during the reset cycle.
   assign a_rvalid = !reset_in && (rd_owner_q == OWNER_A);
   assign b_rvalid = !reset_in && (rd_owner_q == OWNER_B);
   assign a.rvalid = a_rvalid;
   assign b.rvalid = b_rvalid;
   assign a.rdata  = a_rvalid ? ram_rdata : '0;
   assign b.rdata  = b_rvalid ? ram_rdata : '0;

endmodule
